fsmc_frame_rx: RTL and testbench
================================

# fsmc_frame_rx

Parametrised command-frame receiver between the MCU FSMC bus and FPGA control logic. The MCU writes a frame of `DEPTH` words into an internal register file over FSMC, then pulses the `arm_to_fpga` doorbell low. The block snapshots the frame into `data_buffer`, decodes the header word, optionally verifies a checksum, and issues one-cycle acknowledge or error pulses. It runs on a single clock with fully synchronised FSMC strobes. It generalises the fixed 8×16 frame receiver with configurable width, depth and header codes, plus explicit error, overrun and busy reporting.

## Interface
- `DW`, 16, FSMC data / frame word width
- `DEPTH`, 8, words per frame (2..32)
- `AW`, 5, FSMC address bits used; must be ≥ clog2(DEPTH)
- `HDR_PARA`, 16'h1111, header code: parameter configuration
- `HDR_UPLOAD`, 16'h7777, header code: data upload on/off
- `clk_50m`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `fsmc_csn`  in  1  FSMC chip select, active low, asynchronous
- `fsmc_wrn`  in  1  FSMC write strobe, active low, asynchronous
- `fsmc_data`  in  DW  FSMC write data
- `fsmc_addr`  in  AW  FSMC word address
- `arm_to_fpga`  in  1  doorbell; a falling edge starts frame processing; asynchronous
- `para_confi_acq_flag`  out  1  one-cycle pulse: valid HDR_PARA frame
- `data_upload_acq_flag`  out  1  one-cycle pulse: valid HDR_UPLOAD frame
- `frame_err_flag`  out  1  one-cycle pulse: unknown header or checksum mismatch
- `overrun_flag`  out  1  sticky: a write or doorbell arrived while busy
- `busy`  out  1  high while a frame is being snapshot and checked
- `data_buffer`  out  DW*DEPTH  frame snapshot; word 0 in the MSBs

## Operation
- Write strobe `wr_n = fsmc_csn | fsmc_wrn` passes through a 2-flop synchroniser.
- While the synchronised `wr_n` is low, `fsmc_data` and `fsmc_addr` are registered every cycle.
- On the synchronised rising edge of `wr_n`, the registered word is committed to `ram[addr]`.
- Commits with addr ≥ DEPTH are discarded silently.
- Doorbell passes through a 2-flop synchroniser plus an edge register. The fall pulse is `fall`.
- FSM states:
  - IDLE: on `fall`, go to READ, set idx=0, clear the checksum accumulator.
  - READ: copy `ram[idx]` into slot idx of `data_buffer`. Accumulate the checksum over idx 0..DEPTH-2. Increment idx. After idx=DEPTH-1, go to CHECK.
  - CHECK: decode header `data_buffer[DW*DEPTH-1 -: DW]` and register the result into the flags. Go to IDLE.
- Decode result: header == HDR_PARA → `para_confi_acq_flag`; header == HDR_UPLOAD → `data_upload_acq_flag`; any other value → `frame_err_flag`.
- A checksum failure (see Configuration) overrides decode and produces only `frame_err_flag`.
- Exactly one of the three flags pulses per frame.
- Boundary conditions while `busy`:
  - A write commit is dropped; `ram` is unchanged.
  - A `fall` is ignored.
  - Either event sets `overrun_flag`.
- `overrun_flag` clears on the IDLE→READ transition. A set in the same cycle wins over the clear.
- The write path and FSM are independent in IDLE. A commit in the same cycle as `fall` lands in `ram` before READ reads that word.
- Reset mid-frame returns the FSM to IDLE and clears idx and the accumulator. `ram` contents are not reset.
- Arithmetic: the checksum is the modulo-2^DW sum of words, DW bits wide, with carry discarded.

## Timing
- Reset values: all flags 0, `busy` 0, `overrun_flag` 0, `data_buffer` 0, FSM in IDLE.
- Write commit lands 3 clk_50m cycles after the `wr_n` pin rises: 2 synchroniser cycles plus 1 edge cycle.
- The FSMC data hold time after strobe deassertion must cover at least 2 cycles (40 ns).
- `fall` goes high 3 cycles after the doorbell pin falls. Call that cycle T0.
- READ occupies T0+1..T0+DEPTH; CHECK is at T0+DEPTH+1.
- The flag is high for exactly cycle T0+DEPTH+2.
- `busy` is high for T0+1..T0+DEPTH+1.
- `data_buffer` is stable from T0+DEPTH+1 until the next READ.
- Minimum doorbell spacing: DEPTH+2 cycles after T0.

## Configuration
- `FSMC_FRAME_CHECKSUM_EN` defined: word DEPTH-1 is the checksum of words 0..DEPTH-2. A mismatch in CHECK produces `frame_err_flag` regardless of header.
- Not defined: the accumulator is not synthesised, word DEPTH-1 is plain payload, and only the header decides the flag.

## Structure
- Package `fsmc_frame_pkg`: FSM state encoding (IDLE/READ/CHECK), default header constants, and a clog2 helper.
- Sub-module `sync_edge_det`: 2-flop synchroniser plus edge register with `rise` and `fall` outputs. Instantiated twice, for `wr_n` and for `arm_to_fpga`.
- The register file is inferred inside the top module.

## Test plan
- Write 0x1111,1..6,0x0015 to addr 0..7, then drop the doorbell → `para_confi_acq_flag` high for one cycle at T0+10; `data_buffer[127:112]`=0x1111; `frame_err_flag` stays 0.
- Frame with header 0x7777 → `data_upload_acq_flag` pulse only. Frame with header 0x2222 → `frame_err_flag` pulse only.
- With CHECKSUM_EN, a valid header with word 7 = 0x0000 (wrong) → `frame_err_flag` pulse only. Without the macro, the same frame → `para_confi_acq_flag`.
- FSMC write to addr 2 and a second doorbell at T0+4 → `ram[2]` unchanged, `overrun_flag`=1, one flag pulse only. `overrun_flag` clears at the next accepted READ.
- Write to addr 12 → no `ram` change, and `data_buffer` matches the prior contents.
- Assert `rst` during READ (T0+4) → all outputs 0 next cycle and FSM in IDLE. A subsequent doorbell completes normally.

Source files
------------

// File: rtl/fsmc_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_frame_pkg
// Brief    : Shared FSM encoding, default header codes and clog2 helper for
//            the FSMC command-frame receiver.
// Revision : 1.0  initial release
// ============================================================================
package fsmc_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [15:0] C_HDR_PARA_DEF   = 16'h1111;
  localparam logic [15:0] C_HDR_UPLOAD_DEF = 16'h7777;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsmc_frame_rx_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Two-flop synchroniser followed by an edge register; produces
//            single-cycle rise/fall pulses of an asynchronous input.
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle level so no spurious edge appears after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/fsmc_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_frame_rx
// Brief    : FSMC command-frame receiver: register file written over FSMC,
//            doorbell-triggered snapshot, header decode and optional checksum.
//            Optional feature macro: FSMC_FRAME_CHECKSUM_EN
// Revision : 1.0  initial release
// ============================================================================
module fsmc_frame_rx
  import fsmc_frame_pkg::*;
#(
  parameter int             DW         = 16,
  parameter int             DEPTH      = 8,
  parameter int             AW         = 5,
  parameter logic [DW-1:0]  HDR_PARA   = DW'(C_HDR_PARA_DEF),
  parameter logic [DW-1:0]  HDR_UPLOAD = DW'(C_HDR_UPLOAD_DEF)
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  fsmc_csn,
  input  logic                  fsmc_wrn,
  input  logic [DW-1:0]         fsmc_data,
  input  logic [AW-1:0]         fsmc_addr,
  input  logic                  arm_to_fpga,
  output logic                  para_confi_acq_flag,
  output logic                  data_upload_acq_flag,
  output logic                  frame_err_flag,
  output logic                  overrun_flag,
  output logic                  busy,
  output logic [DW*DEPTH-1:0]   data_buffer
);

  localparam int             IW        = clog2(DEPTH);
  localparam logic [IW-1:0]  C_LAST    = IW'(DEPTH - 1);
  localparam logic [AW:0]    C_DEPTH_A = (AW + 1)'(DEPTH);

  logic w_wrn_async;
  logic w_wrn_sync;
  logic w_wr_rise;
  logic w_wr_fall_unused;
  logic w_bell_sync_unused;
  logic w_bell_rise_unused;
  logic w_bell_fall;
  logic w_addr_ok;
  logic w_commit;
  logic w_cks_bad;

  logic [DW-1:0] wdata_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] ram_q [DEPTH];
  logic [DW-1:0] buf_q [DEPTH];

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          para_q;
  logic          upload_q;
  logic          err_q;
  logic          overrun_q;
  logic          overrun_d;
`ifdef FSMC_FRAME_CHECKSUM_EN
  logic [DW-1:0] sum_q;
`endif

  assign w_wrn_async = fsmc_csn | fsmc_wrn;

  sync_edge_det #(.RST_VAL(1'b1)) u_wr_sync (
    .clk_i   (clk_50m),
    .rst_i   (rst),
    .async_i (w_wrn_async),
    .sync_o  (w_wrn_sync),
    .rise_o  (w_wr_rise),
    .fall_o  (w_wr_fall_unused)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_bell_sync (
    .clk_i   (clk_50m),
    .rst_i   (rst),
    .async_i (arm_to_fpga),
    .sync_o  (w_bell_sync_unused),
    .rise_o  (w_bell_rise_unused),
    .fall_o  (w_bell_fall)
  );

  // Data/address track the bus for as long as the synchronised strobe is low.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wdata_q <= '0;
      waddr_q <= '0;
    end else if (!w_wrn_sync) begin
      wdata_q <= fsmc_data;
      waddr_q <= fsmc_addr;
    end
  end

  assign w_addr_ok = ({1'b0, waddr_q} < C_DEPTH_A);
  assign w_commit  = w_wr_rise && w_addr_ok && !busy_q;

  always_ff @(posedge clk_50m) begin
    if (w_commit) begin
      ram_q[waddr_q[IW-1:0]] <= wdata_q;
    end
  end

`ifdef FSMC_FRAME_CHECKSUM_EN
  assign w_cks_bad = (sum_q != buf_q[DEPTH-1]);
`else
  assign w_cks_bad = 1'b0;
`endif

  // A set from a busy-time event takes priority over the clear on frame start.
  always_comb begin
    overrun_d = overrun_q;
    if (state_q == ST_IDLE && w_bell_fall) begin
      overrun_d = 1'b0;
    end
    if (busy_q && (w_wr_rise || w_bell_fall)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      para_q    <= 1'b0;
      upload_q  <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
`ifdef FSMC_FRAME_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      para_q    <= 1'b0;
      upload_q  <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (w_bell_fall) begin
            state_q <= ST_READ;
            idx_q   <= '0;
            busy_q  <= 1'b1;
`ifdef FSMC_FRAME_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        ST_READ: begin
          buf_q[idx_q] <= ram_q[idx_q];
`ifdef FSMC_FRAME_CHECKSUM_EN
          if (idx_q != C_LAST) begin
            sum_q <= sum_q + ram_q[idx_q];
          end
`endif
          if (idx_q == C_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (w_cks_bad) begin
            err_q <= 1'b1;
          end else if (buf_q[0] == HDR_PARA) begin
            para_q <= 1'b1;
          end else if (buf_q[0] == HDR_UPLOAD) begin
            upload_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign data_buffer[DW*(DEPTH-g)-1 -: DW] = buf_q[g];
  end

  assign para_confi_acq_flag  = para_q;
  assign data_upload_acq_flag = upload_q;
  assign frame_err_flag       = err_q;
  assign overrun_flag         = overrun_q;
  assign busy                 = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsmc_frame_rx
// Brief    : Self-checking bench for fsmc_frame_rx (table, corner sequences,
//            random frames against a behavioural frame model).
// Revision : 1.0  initial release
// ============================================================================
module tb_fsmc_frame_rx;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int BW    = DW * DEPTH;
  localparam logic [DW-1:0] P_PARA = 16'h1111;
  localparam logic [DW-1:0] P_UPL  = 16'h7777;
  localparam int F_PARA = 0;
  localparam int F_UPL  = 1;
  localparam int F_ERR  = 2;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          fsmc_csn = 1'b1;
  logic          fsmc_wrn = 1'b1;
  logic [DW-1:0] fsmc_data = '0;
  logic [AW-1:0] fsmc_addr = '0;
  logic          arm_to_fpga = 1'b1;
  logic          para_confi_acq_flag;
  logic          data_upload_acq_flag;
  logic          frame_err_flag;
  logic          overrun_flag;
  logic          busy;
  logic [BW-1:0] data_buffer;

  fsmc_frame_rx #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50m              (clk_50m),
    .rst                  (rst),
    .fsmc_csn             (fsmc_csn),
    .fsmc_wrn             (fsmc_wrn),
    .fsmc_data            (fsmc_data),
    .fsmc_addr            (fsmc_addr),
    .arm_to_fpga          (arm_to_fpga),
    .para_confi_acq_flag  (para_confi_acq_flag),
    .data_upload_acq_flag (data_upload_acq_flag),
    .frame_err_flag       (frame_err_flag),
    .overrun_flag         (overrun_flag),
    .busy                 (busy),
    .data_buffer          (data_buffer)
  );

  always #10 clk_50m = ~clk_50m;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mram [DEPTH];
  logic [DW-1:0] snap [DEPTH];

  typedef struct {
    logic [DW-1:0] hdr;
    logic [DW-1:0] w7;
    int            exp_plain;
    int            exp_cks;
  } vec_t;
  vec_t tbl [5];

  task automatic tick();
    @(negedge clk_50m);
  endtask

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fsmc_write(input int a, input logic [DW-1:0] d);
    fsmc_addr = AW'(a);
    fsmc_data = d;
    fsmc_csn  = 1'b0;
    fsmc_wrn  = 1'b0;
    repeat (3) tick();
    fsmc_csn  = 1'b1;
    fsmc_wrn  = 1'b1;
    repeat (5) tick();
    if (a < DEPTH) mram[a] = d;
  endtask

  function automatic int model_code();
`ifdef FSMC_FRAME_CHECKSUM_EN
    int s;
    s = 0;
    for (int i = 0; i < DEPTH - 1; i++) s += int'(mram[i]);
    if ((s % (1 << DW)) != int'(mram[DEPTH-1])) return F_ERR;
`endif
    if (mram[0] == P_PARA) return F_PARA;
    if (mram[0] == P_UPL) return F_UPL;
    return F_ERR;
  endfunction

  function automatic logic [BW-1:0] pack_snap();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v = (v << DW) | BW'(snap[i]);
    return v;
  endfunction

  // Rings the doorbell and observes the whole frame relative to the first
  // busy cycle (T0+1). With ovr set, a write to addr 2 and a second doorbell
  // are issued while the frame is in progress.
  task automatic ring(input string tag, input int exp_code, input bit ovr);
    int   t;
    int   n_busy;
    int   cnt [3];
    int   at [3];
    logic [2:0] f;
    for (int i = 0; i < DEPTH; i++) snap[i] = mram[i];
    arm_to_fpga = 1'b0;
    t = 0;
    while (busy !== 1'b1 && t < 12) begin
      tick();
      t++;
    end
    chk($sformatf("%s.busy_rise", tag), BW'(busy), BW'(1));
    arm_to_fpga = 1'b1;
    if (busy !== 1'b1) return;
    n_busy = 0;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      at[k]  = -1;
    end
    for (int n = 0; n < DEPTH + 4; n++) begin
      if (ovr && n == 2) begin
        fsmc_addr   = AW'(2);
        fsmc_data   = 16'hDEAD;
        fsmc_csn    = 1'b0;
        fsmc_wrn    = 1'b0;
        arm_to_fpga = 1'b0;
      end
      if (ovr && n == 4) begin
        fsmc_csn    = 1'b1;
        fsmc_wrn    = 1'b1;
        arm_to_fpga = 1'b1;
      end
      if (busy === 1'b1) n_busy++;
      f = {frame_err_flag, data_upload_acq_flag, para_confi_acq_flag};
      for (int k = 0; k < 3; k++) begin
        if (f[k] === 1'b1) begin
          cnt[k]++;
          at[k] = n;
        end
      end
      tick();
    end
    chk($sformatf("%s.busy_len", tag), BW'(n_busy), BW'(DEPTH + 1));
    chk($sformatf("%s.flag_cnt", tag), BW'(cnt[0] + cnt[1] + cnt[2]), BW'(1));
    chk($sformatf("%s.flag_at", tag), BW'(at[exp_code]), BW'(DEPTH + 1));
    chk($sformatf("%s.dbuf", tag), data_buffer, pack_snap());
    chk($sformatf("%s.overrun", tag), BW'(overrun_flag), BW'(ovr));
  endtask

  initial begin
    logic [DW-1:0] hdr;
    logic [DW-1:0] w7;
    int            kind;
    int            exp;

    tbl[0] = '{hdr: 16'h1111, w7: 16'h1126, exp_plain: F_PARA, exp_cks: F_PARA};
    tbl[1] = '{hdr: 16'h7777, w7: 16'h778C, exp_plain: F_UPL,  exp_cks: F_UPL};
    tbl[2] = '{hdr: 16'h2222, w7: 16'h2237, exp_plain: F_ERR,  exp_cks: F_ERR};
    tbl[3] = '{hdr: 16'h1111, w7: 16'h0000, exp_plain: F_PARA, exp_cks: F_ERR};
    tbl[4] = '{hdr: 16'h1111, w7: 16'h0015, exp_plain: F_PARA, exp_cks: F_ERR};

    repeat (3) tick();
    chk("rst.busy", BW'(busy), '0);
    chk("rst.flags", BW'({frame_err_flag, data_upload_acq_flag, para_confi_acq_flag}), '0);
    chk("rst.overrun", BW'(overrun_flag), '0);
    chk("rst.dbuf", data_buffer, '0);
    rst = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 5; v++) begin
      fsmc_write(0, tbl[v].hdr);
      for (int i = 1; i < DEPTH - 1; i++) fsmc_write(i, DW'(i));
      fsmc_write(DEPTH - 1, tbl[v].w7);
`ifdef FSMC_FRAME_CHECKSUM_EN
      exp = tbl[v].exp_cks;
`else
      exp = tbl[v].exp_plain;
`endif
      ring($sformatf("tbl%0d", v), exp, 1'b0);
    end

    ring("ovr", model_code(), 1'b1);
    ring("ovr_after", model_code(), 1'b0);

    fsmc_write(12, 16'hBEEF);
    ring("addr12", model_code(), 1'b0);

    // Reset in the middle of READ.
    arm_to_fpga = 1'b0;
    for (int t = 0; t < 12 && busy !== 1'b1; t++) tick();
    arm_to_fpga = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst.busy", BW'(busy), '0);
    chk("midrst.flags", BW'({frame_err_flag, data_upload_acq_flag, para_confi_acq_flag}), '0);
    chk("midrst.overrun", BW'(overrun_flag), '0);
    chk("midrst.dbuf", data_buffer, '0);
    rst = 1'b0;
    repeat (3) tick();
    ring("postrst", model_code(), 1'b0);

    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 2);
      hdr  = (kind == 0) ? P_PARA : (kind == 1) ? P_UPL : DW'($urandom);
      fsmc_write(0, hdr);
      for (int i = 1; i < DEPTH - 1; i++) begin
        if ($urandom_range(0, 3) != 0) fsmc_write(i, DW'($urandom));
      end
      if ($urandom_range(0, 3) == 0) fsmc_write($urandom_range(DEPTH, 31), DW'($urandom));
      w7 = DW'($urandom);
`ifdef FSMC_FRAME_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) begin
        int s;
        s = 0;
        for (int i = 0; i < DEPTH - 1; i++) s += int'(mram[i]);
        w7 = DW'(s);
      end
`endif
      fsmc_write(DEPTH - 1, w7);
      ring($sformatf("rnd%0d", r), model_code(), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
